// File: rtl/matrix_alu_pkg.sv
// Shared constants and state encoding for the matrix ALU sequencer.
// Operation codes, error codes and the sequencer state type.
package matrix_alu_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] OPC_IDLE = 3'b000;
  localparam logic [2:0] OPC_ADD  = 3'b001;
  localparam logic [2:0] OPC_SUB  = 3'b011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALU     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_FINISH,
    S_ABORT
  } seq_state_t;

endpackage

// File: rtl/matrix_row_bank.sv
// 4-row x 4-element register file: one synchronous write port, one
// combinational read port, synchronous clear.
module matrix_row_bank #(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [1:0]             wr_row,
  input  logic [3:0][DATA_W-1:0] wr_data,
  input  logic [1:0]             rd_row,
  output logic [3:0][DATA_W-1:0] rd_data
);

  logic [3:0][3:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Issues one ALU operation per row of two 4x4 operand matrices and
// collects the returned rows into a result matrix.
//
// state   | meaning
// IDLE    | waiting for Start; operand loads accepted
// ISSUE   | present row operands and opcode for one cycle
// WAIT    | hold operands, wait for ALU Done/Error or timeout
// RELEASE | Operation back to idle until the ALU drops Done
// FINISH  | one-cycle Done pulse
// ABORT   | one cycle with Operation idle after an error
module matrix_alu_sequencer
  import matrix_alu_pkg::*;
#(
  parameter int         DATA_W  = DATA_W_DEF,
  parameter int         TIMEOUT = 64,
  parameter logic [2:0] OP_IDLE = OPC_IDLE
) (
  input  logic                     Clock,
  input  logic                     ClearAll,
  input  logic                     Start,
  input  logic [2:0]               OpCode,
  input  logic                     LoadEnable,
  input  logic                     LoadMatrix,
  input  logic [1:0]               LoadRow,
  input  logic signed [DATA_W-1:0] LoadData1,
  input  logic signed [DATA_W-1:0] LoadData2,
  input  logic signed [DATA_W-1:0] LoadData3,
  input  logic signed [DATA_W-1:0] LoadData4,
  input  logic [1:0]               ReadRow,
  output logic signed [DATA_W-1:0] ReadData1,
  output logic signed [DATA_W-1:0] ReadData2,
  output logic signed [DATA_W-1:0] ReadData3,
  output logic signed [DATA_W-1:0] ReadData4,
  output logic [2:0]               Operation,
  output logic signed [DATA_W-1:0] ColumnA1,
  output logic signed [DATA_W-1:0] ColumnA2,
  output logic signed [DATA_W-1:0] ColumnA3,
  output logic signed [DATA_W-1:0] ColumnA4,
  output logic signed [DATA_W-1:0] ColumnB1,
  output logic signed [DATA_W-1:0] ColumnB2,
  output logic signed [DATA_W-1:0] ColumnB3,
  output logic signed [DATA_W-1:0] ColumnB4,
  input  logic                     AluDone,
  input  logic                     AluError,
  input  logic signed [DATA_W-1:0] NewColumn1,
  input  logic signed [DATA_W-1:0] NewColumn2,
  input  logic signed [DATA_W-1:0] NewColumn3,
  input  logic signed [DATA_W-1:0] NewColumn4,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic [1:0]               ErrorCode
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t       state, state_n;
  logic [1:0]       row, row_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic             err_q, err_n;
  logic [1:0]       code_q, code_n;

  logic [3:0][DATA_W-1:0] load_row, a_row, b_row, alu_row, res_row;
  logic                   a_we, b_we, res_we, drive;

  assign load_row = {LoadData4, LoadData3, LoadData2, LoadData1};
  assign alu_row  = {NewColumn4, NewColumn3, NewColumn2, NewColumn1};

  // Operands are frozen while a run is in progress.
  assign a_we   = LoadEnable && (state == S_IDLE) && !LoadMatrix;
  assign b_we   = LoadEnable && (state == S_IDLE) &&  LoadMatrix;
  assign res_we = (state == S_WAIT) && !AluError && AluDone;

  matrix_row_bank #(.DATA_W(DATA_W)) u_bank_a (
    .clk(Clock), .rst(ClearAll), .wr_en(a_we), .wr_row(LoadRow),
    .wr_data(load_row), .rd_row(row), .rd_data(a_row)
  );

  matrix_row_bank #(.DATA_W(DATA_W)) u_bank_b (
    .clk(Clock), .rst(ClearAll), .wr_en(b_we), .wr_row(LoadRow),
    .wr_data(load_row), .rd_row(row), .rd_data(b_row)
  );

  matrix_row_bank #(.DATA_W(DATA_W)) u_bank_res (
    .clk(Clock), .rst(ClearAll), .wr_en(res_we), .wr_row(row),
    .wr_data(alu_row), .rd_row(ReadRow), .rd_data(res_row)
  );

  always_ff @(posedge Clock) begin
    if (ClearAll) begin
      state  <= S_IDLE;
      row    <= '0;
      cnt    <= '0;
      op_q   <= OP_IDLE;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state  <= state_n;
      row    <= row_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      err_q  <= err_n;
      code_q <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    cnt_n   = cnt;
    op_n    = op_q;
    err_n   = err_q;
    code_n  = code_q;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (OpCode == OP_IDLE) begin
            err_n  = 1'b1;
            code_n = ERR_ILLEGAL;
          end else begin
            op_n    = OpCode;
            err_n   = 1'b0;
            code_n  = ERR_NONE;
            row_n   = '0;
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (AluError) begin
          err_n   = 1'b1;
          code_n  = ERR_ALU;
          state_n = S_ABORT;
        end else if (AluDone) begin
          state_n = S_RELEASE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = S_ABORT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!AluDone) begin
          if (row == 2'd3) begin
            state_n = S_FINISH;
          end else begin
            row_n   = row + 2'd1;
            state_n = S_ISSUE;
          end
        end
      end
      S_FINISH: state_n = S_IDLE;
      S_ABORT:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Operands and opcode are presented only while the ALU owns the row.
  assign drive     = (state == S_ISSUE) || (state == S_WAIT);
  assign Operation = drive ? op_q : OP_IDLE;
  assign ColumnA1  = drive ? a_row[0] : '0;
  assign ColumnA2  = drive ? a_row[1] : '0;
  assign ColumnA3  = drive ? a_row[2] : '0;
  assign ColumnA4  = drive ? a_row[3] : '0;
  assign ColumnB1  = drive ? b_row[0] : '0;
  assign ColumnB2  = drive ? b_row[1] : '0;
  assign ColumnB3  = drive ? b_row[2] : '0;
  assign ColumnB4  = drive ? b_row[3] : '0;

  assign ReadData1 = res_row[0];
  assign ReadData2 = res_row[1];
  assign ReadData3 = res_row[2];
  assign ReadData4 = res_row[3];

  assign Busy      = (state != S_IDLE);
  assign Done      = (state == S_FINISH);
  assign Error     = err_q;
  assign ErrorCode = code_q;

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Directed bench for matrix_alu_sequencer with a small behavioural
// subtracting ALU that answers one cycle after an operation appears.
module tb_matrix_alu_sequencer;

  localparam int DW = 32;

  logic Clock = 1'b0;
  logic ClearAll, Start, LoadEnable, LoadMatrix;
  logic [2:0] OpCode, Operation;
  logic [1:0] LoadRow, ReadRow, ErrorCode;
  logic signed [DW-1:0] LoadData1, LoadData2, LoadData3, LoadData4;
  logic signed [DW-1:0] ReadData1, ReadData2, ReadData3, ReadData4;
  logic signed [DW-1:0] ColumnA1, ColumnA2, ColumnA3, ColumnA4;
  logic signed [DW-1:0] ColumnB1, ColumnB2, ColumnB3, ColumnB4;
  logic signed [DW-1:0] NewColumn1, NewColumn2, NewColumn3, NewColumn4;
  logic AluDone, AluError, Busy, Done, Error;

  logic alu_pend;
  bit   done_en, err_en;
  int   n_vec, n_miss;

  always #5 Clock = ~Clock;

  matrix_alu_sequencer #(.DATA_W(DW), .TIMEOUT(8), .OP_IDLE(3'b000)) dut (
    .Clock(Clock), .ClearAll(ClearAll), .Start(Start), .OpCode(OpCode),
    .LoadEnable(LoadEnable), .LoadMatrix(LoadMatrix), .LoadRow(LoadRow),
    .LoadData1(LoadData1), .LoadData2(LoadData2), .LoadData3(LoadData3), .LoadData4(LoadData4),
    .ReadRow(ReadRow),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ReadData3(ReadData3), .ReadData4(ReadData4),
    .Operation(Operation),
    .ColumnA1(ColumnA1), .ColumnA2(ColumnA2), .ColumnA3(ColumnA3), .ColumnA4(ColumnA4),
    .ColumnB1(ColumnB1), .ColumnB2(ColumnB2), .ColumnB3(ColumnB3), .ColumnB4(ColumnB4),
    .AluDone(AluDone), .AluError(AluError),
    .NewColumn1(NewColumn1), .NewColumn2(NewColumn2), .NewColumn3(NewColumn3), .NewColumn4(NewColumn4),
    .Busy(Busy), .Done(Done), .Error(Error), .ErrorCode(ErrorCode)
  );

  // Behavioural ALU: result ready one cycle after an op appears, Done
  // withdrawn as soon as Operation returns to idle.
  always @(posedge Clock) begin
    if (ClearAll) alu_pend <= 1'b0;
    else          alu_pend <= (Operation != 3'b000);
  end
  assign AluDone    = done_en && alu_pend && (Operation != 3'b000);
  assign AluError   = err_en && alu_pend && (Operation != 3'b000) && (ColumnA1 == 30);
  assign NewColumn1 = ColumnA1 - ColumnB1;
  assign NewColumn2 = ColumnA2 - ColumnB2;
  assign NewColumn3 = ColumnA3 - ColumnB3;
  assign NewColumn4 = ColumnA4 - ColumnB4;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_row(input logic m, input logic [1:0] r, input int v);
    LoadEnable = 1'b1; LoadMatrix = m; LoadRow = r;
    LoadData1 = v; LoadData2 = v; LoadData3 = v; LoadData4 = v;
    tick();
    LoadEnable = 1'b0;
  endtask

  task automatic load_mat(input logic m, input int base, input int step);
    for (int r = 0; r < 4; r++) load_row(m, 2'(r), base + step * r);
  endtask

  task automatic check_row(input string tag, input int r, input int exp);
    ReadRow = 2'(r);
    #1;
    chk({tag, "_c1"}, ReadData1, exp);
    chk({tag, "_c2"}, ReadData2, exp);
    chk({tag, "_c3"}, ReadData3, exp);
    chk({tag, "_c4"}, ReadData4, exp);
  endtask

  task automatic run(input logic [2:0] op, input bit disturb,
                     output int done_k, output int busy_n, output int opact_n, output int dcount);
    done_k = 0; busy_n = 0; opact_n = 0; dcount = 0;
    Start = 1'b1; OpCode = op;
    for (int k = 1; k <= 60; k++) begin
      tick();
      Start = 1'b0; LoadEnable = 1'b0;
      if (Done) begin
        dcount++;
        if (done_k == 0) done_k = k;
      end
      if (Busy) busy_n++;
      if (Operation != 3'b000) opact_n++;
      if (disturb && k == 5) begin
        LoadEnable = 1'b1; LoadMatrix = 1'b0; LoadRow = 2'd3;
        LoadData1 = 100; LoadData2 = 100; LoadData3 = 100; LoadData4 = 100;
        Start = 1'b1; OpCode = 3'b000;
      end
      if (!Busy && k > 1) break;
    end
    chk("run_bound_busy", Busy, 0);
  endtask

  int done_k, busy_n, opact_n, dcount;

  initial begin
    n_vec = 0; n_miss = 0; done_en = 1'b1; err_en = 1'b0;
    ClearAll = 1'b1; Start = 1'b0; OpCode = 3'b000; LoadEnable = 1'b0;
    LoadMatrix = 1'b0; LoadRow = 2'd0; ReadRow = 2'd0;
    LoadData1 = 0; LoadData2 = 0; LoadData3 = 0; LoadData4 = 0;
    tick(); tick();
    ClearAll = 1'b0;

    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_code", ErrorCode, 0);
    chk("rst_op", Operation, 0);
    chk("rst_cola1", ColumnA1, 0);
    chk("rst_colb4", ColumnB4, 0);
    check_row("rst_res0", 0, 0);

    // Full subtract run: 4 - 1 = 3 on every element
    load_mat(1'b0, 4, 0);
    load_mat(1'b1, 1, 0);
    run(3'b011, 1'b0, done_k, busy_n, opact_n, dcount);
    chk("sub_done_cycle", done_k, 13);
    chk("sub_done_count", dcount, 1);
    chk("sub_error", Error, 0);
    chk("sub_op_idle", Operation, 0);
    for (int r = 0; r < 4; r++) check_row($sformatf("sub_row%0d", r), r, 3);

    // Start with the idle opcode is rejected
    Start = 1'b1; OpCode = 3'b000;
    tick();
    Start = 1'b0;
    chk("ill_error", Error, 1);
    chk("ill_code", ErrorCode, 3);
    chk("ill_busy", Busy, 0);
    chk("ill_op", Operation, 0);
    tick();
    chk("ill_busy_later", Busy, 0);

    // ALU never answers: 1 ISSUE + 8 WAIT + 1 ABORT busy cycles
    done_en = 1'b0;
    run(3'b011, 1'b0, done_k, busy_n, opact_n, dcount);
    done_en = 1'b1;
    chk("to_busy_cycles", busy_n, 10);
    chk("to_op_cycles", opact_n, 9);
    chk("to_error", Error, 1);
    chk("to_code", ErrorCode, 2);
    chk("to_done_count", dcount, 0);
    chk("to_op_idle", Operation, 0);
    check_row("to_res0", 0, 3);

    // ALU error together with Done on row 2
    load_mat(1'b0, 10, 10);
    err_en = 1'b1;
    run(3'b011, 1'b0, done_k, busy_n, opact_n, dcount);
    err_en = 1'b0;
    chk("ae_error", Error, 1);
    chk("ae_code", ErrorCode, 1);
    chk("ae_done_count", dcount, 0);
    check_row("ae_row0", 0, 9);
    check_row("ae_row1", 1, 19);
    check_row("ae_row2", 2, 3);
    check_row("ae_row3", 3, 3);

    // ClearAll during WAIT of row 1
    Start = 1'b1; OpCode = 3'b011;
    tick();
    Start = 1'b0;
    begin
      int guard = 0;
      while (!(Operation != 3'b000 && ColumnA1 == 20) && guard < 40) begin
        tick();
        guard++;
      end
      chk("clr_reach_row1", guard < 40, 1);
    end
    tick();
    ClearAll = 1'b1;
    tick();
    chk("clr_busy", Busy, 0);
    chk("clr_done", Done, 0);
    chk("clr_error", Error, 0);
    chk("clr_code", ErrorCode, 0);
    chk("clr_op", Operation, 0);
    chk("clr_cola1", ColumnA1, 0);
    check_row("clr_res0", 0, 0);
    ClearAll = 1'b0;
    tick();
    load_mat(1'b0, 4, 0);
    load_mat(1'b1, 1, 0);
    run(3'b011, 1'b0, done_k, busy_n, opact_n, dcount);
    chk("clr_rerun_done", dcount, 1);
    check_row("clr_rerun_row1", 1, 3);

    // Load and Start attempts mid-run are ignored
    run(3'b011, 1'b1, done_k, busy_n, opact_n, dcount);
    chk("mid_done_cycle", done_k, 13);
    chk("mid_done_count", dcount, 1);
    chk("mid_error", Error, 0);
    check_row("mid_row3", 3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
